// File: rtl/dp_ram_pkg.sv
// Shared types and helpers for the dp_ram storage primitive.
package dp_ram_pkg;
  typedef enum logic {INIT, RUN} state_t;

  localparam int BYTE_WD    = 8;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  // Even-parity bit: the stored bit makes the byte plus parity have an even count of ones.
  function automatic logic byte_par(input logic [BYTE_WD-1:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/dp_ram_rd_pipe.sv
// Read-side delay line: lat register stages carrying {valid, data, perr}.
module dp_ram_rd_pipe #(
  parameter int lat = 1,
  parameter int dw  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [dw-1:0] in_data,
  input  logic          in_perr,
  output logic          out_valid,
  output logic [dw-1:0] out_data,
  output logic          out_perr
);
  localparam int STAGES = lat - 1;

  logic [STAGES:0]         vld_pipe;
  logic [STAGES:0]         perr_pipe;
  logic [STAGES:0][dw-1:0] data_pipe;

  // Data only advances with a valid beat, so the output holds its last read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      perr_pipe <= '0;
      data_pipe <= '0;
    end else begin
      vld_pipe[0]  <= in_valid;
      perr_pipe[0] <= in_valid & in_perr;
      if (in_valid) data_pipe[0] <= in_data;
      for (int s = 1; s <= STAGES; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        perr_pipe[s] <= vld_pipe[s-1] & perr_pipe[s-1];
        if (vld_pipe[s-1]) data_pipe[s] <= data_pipe[s-1];
      end
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign out_data  = data_pipe[STAGES];
  assign out_perr  = perr_pipe[STAGES];
endmodule

// File: rtl/dp_ram.sv
// Simple dual-port RAM with byte enables, write-first forwarding and a post-reset clear sweep.
// Optional per-byte even parity is enabled with `define DP_RAM_PARITY_EN.
module dp_ram
  import dp_ram_pkg::*;
#(
  parameter int add_wd  = 4,
  parameter int data_wd = 32,
  parameter int depth   = 16,
  parameter int rd_lat  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [add_wd-1:0]     wr_add,
  input  logic [data_wd-1:0]    wr_data,
  input  logic [data_wd/8-1:0]  wr_be,
  input  logic                  rd_en,
  input  logic [add_wd-1:0]     rd_add,
  output logic [data_wd-1:0]    rd_data,
  output logic                  rd_valid,
  output logic                  rd_perr,
  input  logic                  wr_perr_inj,
  output logic                  init_done
);
  localparam int NB = data_wd / BYTE_WD;
  localparam logic [add_wd:0]   DEPTH_L = (add_wd+1)'(depth);
  localparam logic [add_wd-1:0] LAST    = add_wd'(depth - 1);

  if (data_wd % BYTE_WD != 0) begin : g_bad_wd
    $error("dp_ram: data_wd must be a multiple of 8");
  end
  if (depth < 1 || depth > (1 << add_wd)) begin : g_bad_depth
    $error("dp_ram: depth must be in 1..2**add_wd");
  end
  if (rd_lat < RD_LAT_MIN || rd_lat > RD_LAT_MAX) begin : g_bad_lat
    $error("dp_ram: rd_lat out of range");
  end

  state_t            state_q, state_d;
  logic [add_wd-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end
  end

  assign init_done = (state_q == RUN);

  logic wr_go, rd_go, rd_rng, fwd;
  assign wr_go  = init_done && wr_en && ({1'b0, wr_add} < DEPTH_L);
  assign rd_go  = init_done && rd_en;
  assign rd_rng = {1'b0, rd_add} < DEPTH_L;
  assign fwd    = wr_go && (wr_add == rd_add);

  logic [data_wd-1:0] mem [depth];
`ifdef DP_RAM_PARITY_EN
  logic [NB-1:0] par [depth];
`else
  logic unused_inj;
  assign unused_inj = wr_perr_inj;
`endif

  // No reset on the array itself; the INIT sweep is what clears it.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      mem[cnt_q] <= '0;
`ifdef DP_RAM_PARITY_EN
      par[cnt_q] <= '0;
`endif
    end else if (wr_go) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) begin
          mem[wr_add][b*BYTE_WD +: BYTE_WD] <= wr_data[b*BYTE_WD +: BYTE_WD];
`ifdef DP_RAM_PARITY_EN
          par[wr_add][b] <= byte_par(wr_data[b*BYTE_WD +: BYTE_WD]) ^ wr_perr_inj;
`endif
        end
      end
    end
  end

  logic [data_wd-1:0] rd_word;
  logic               rd_err;

  // Write-first merge per byte; out-of-range reads return zero with no error.
  always_comb begin
    rd_word = '0;
    rd_err  = 1'b0;
    if (rd_rng) begin
      for (int b = 0; b < NB; b++) begin
        if (fwd && wr_be[b]) rd_word[b*BYTE_WD +: BYTE_WD] = wr_data[b*BYTE_WD +: BYTE_WD];
        else                 rd_word[b*BYTE_WD +: BYTE_WD] = mem[rd_add][b*BYTE_WD +: BYTE_WD];
`ifdef DP_RAM_PARITY_EN
        rd_err = rd_err | (byte_par(rd_word[b*BYTE_WD +: BYTE_WD]) ^
                 ((fwd && wr_be[b]) ? (byte_par(wr_data[b*BYTE_WD +: BYTE_WD]) ^ wr_perr_inj)
                                    : par[rd_add][b]));
`endif
      end
    end
  end

  dp_ram_rd_pipe #(.lat(rd_lat), .dw(data_wd)) u_rd_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (rd_go),
    .in_data  (rd_word),
    .in_perr  (rd_err),
    .out_valid(rd_valid),
    .out_data (rd_data),
    .out_perr (rd_perr)
  );
endmodule

// File: tb/tb_dp_ram.sv
// Directed bench: a depth-16/latency-3 and a depth-12/latency-1 instance driven in lockstep.
module tb_dp_ram;
`ifdef DP_RAM_PARITY_EN
  localparam logic PAR = 1'b1;
`else
  localparam logic PAR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, wr_en, wr_perr_inj, rd_en;
  logic [3:0]  wr_add, rd_add, wr_be;
  logic [31:0] wr_data;
  logic [31:0] d16, d12;
  logic        v16, v12, p16, p12, i16, i12;

  always #5 clk = ~clk;

  dp_ram #(.add_wd(4), .data_wd(32), .depth(16), .rd_lat(3)) u16 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_add(wr_add), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_add(rd_add), .rd_data(d16), .rd_valid(v16),
    .rd_perr(p16), .wr_perr_inj(wr_perr_inj), .init_done(i16));

  dp_ram #(.add_wd(4), .data_wd(32), .depth(12), .rd_lat(1)) u12 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_add(wr_add), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_add(rd_add), .rd_data(d12), .rd_valid(v12),
    .rd_perr(p12), .wr_perr_inj(wr_perr_inj), .init_done(i12));

  typedef struct {
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        inj;
    logic        re;
    logic [3:0]  ra;
    logic [31:0] e16;
    logic [31:0] e12;
    logic        ep;
  } vec_t;

  vec_t tbl[14];
  int   pass = 0;
  int   total = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s: got %b expected %b", nm, got, exp);
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_add = '0; wr_data = '0; wr_be = '0; wr_perr_inj = 1'b0;
    rd_en = 1'b0; rd_add = '0;
  endtask

  function automatic logic [31:0] pat(input int i, input logic zero);
    return zero ? 32'h0 : 32'(i) * 32'h01010101;
  endfunction

  // Release reset with requests held high; they must be ignored until init_done.
  task automatic init_seq();
    @(negedge clk);
    rst_n = 1'b1;
    wr_en = 1'b1; wr_add = 4'd13; wr_data = '1; wr_be = '1; rd_en = 1'b1; rd_add = 4'd13;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk1("u16_init_done", i16, k == 16);
      chk1("u16_init_vld", v16, 1'b0);
      chk1("u12_init_done", i12, k >= 12);
      if (k <= 12) chk1("u12_init_vld", v12, 1'b0);
    end
    idle();
    repeat (3) @(negedge clk);
  endtask

  // One stimulus beat, then check the latency-1 and latency-3 outputs at their slots.
  task automatic apply(input vec_t v);
    @(negedge clk);
    wr_en = v.we; wr_add = v.wa; wr_data = v.wd; wr_be = v.be; wr_perr_inj = v.inj;
    rd_en = v.re; rd_add = v.ra;
    @(negedge clk);
    idle();
    chk1("u12_vld", v12, v.re);
    if (v.re) begin
      chk("u12_data", d12, v.e12);
      chk1("u12_perr", p12, v.ep);
    end
    chk1("u16_early_vld", v16, 1'b0);
    repeat (2) @(negedge clk);
    chk1("u16_vld", v16, v.re);
    if (v.re) begin
      chk("u16_data", d16, v.e16);
      chk1("u16_perr", p16, v.ep);
    end
  endtask

  // Back-to-back reads of addresses 0..n-1.
  task automatic burst(input int n, input logic zero);
    for (int c = 0; c <= n + 3; c++) begin
      @(negedge clk);
      chk1("b16_vld", v16, (c >= 3) && (c < n + 3));
      if (c >= 3 && c < n + 3) chk("b16_data", d16, pat(c - 3, zero));
      chk1("b12_vld", v12, (c >= 1) && (c <= n));
      if (c >= 1 && c <= n) chk("b12_data", d12, (c - 1 < 12) ? pat(c - 1, zero) : 32'h0);
      if (c < n) begin
        rd_en = 1'b1; rd_add = 4'(c);
      end else begin
        rd_en = 1'b0; rd_add = '0;
      end
    end
  endtask

  initial begin
    //          we    wa     wd            be       inj   re    ra     e16           e12           ep
    tbl[0]  = '{1'b1, 4'd3,  32'hDEADBEEF, 4'b0101, 1'b0, 1'b0, 4'd0,  32'h0,        32'h0,        1'b0};
    tbl[1]  = '{1'b0, 4'd0,  32'h0,        4'b0000, 1'b0, 1'b1, 4'd3,  32'h00AD00EF, 32'h00AD00EF, 1'b0};
    tbl[2]  = '{1'b1, 4'd5,  32'hAABBCCDD, 4'b1111, 1'b0, 1'b0, 4'd0,  32'h0,        32'h0,        1'b0};
    tbl[3]  = '{1'b1, 4'd5,  32'h11223344, 4'b1100, 1'b0, 1'b1, 4'd5,  32'h1122CCDD, 32'h1122CCDD, 1'b0};
    tbl[4]  = '{1'b1, 4'd14, 32'hABCD1234, 4'b1111, 1'b0, 1'b0, 4'd0,  32'h0,        32'h0,        1'b0};
    tbl[5]  = '{1'b0, 4'd0,  32'h0,        4'b0000, 1'b0, 1'b1, 4'd14, 32'hABCD1234, 32'h0,        1'b0};
    tbl[6]  = '{1'b1, 4'd3,  32'hFFFFFFFF, 4'b0000, 1'b0, 1'b0, 4'd0,  32'h0,        32'h0,        1'b0};
    tbl[7]  = '{1'b0, 4'd0,  32'h0,        4'b0000, 1'b0, 1'b1, 4'd3,  32'h00AD00EF, 32'h00AD00EF, 1'b0};
    tbl[8]  = '{1'b0, 4'd0,  32'h0,        4'b0000, 1'b0, 1'b1, 4'd11, 32'h0,        32'h0,        1'b0};
    tbl[9]  = '{1'b1, 4'd2,  32'h00000055, 4'b0001, 1'b1, 1'b0, 4'd0,  32'h0,        32'h0,        1'b0};
    tbl[10] = '{1'b0, 4'd0,  32'h0,        4'b0000, 1'b0, 1'b1, 4'd2,  32'h00000055, 32'h00000055, PAR};
    tbl[11] = '{1'b0, 4'd0,  32'h0,        4'b0000, 1'b0, 1'b1, 4'd1,  32'h0,        32'h0,        1'b0};
    tbl[12] = '{1'b1, 4'd15, 32'h12345678, 4'b1000, 1'b0, 1'b1, 4'd15, 32'h12000000, 32'h0,        1'b0};
    tbl[13] = '{1'b0, 4'd0,  32'h0,        4'b0000, 1'b0, 1'b1, 4'd5,  32'h1122CCDD, 32'h1122CCDD, 1'b0};

    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_u16_data", d16, 32'h0);
    chk1("rst_u16_vld", v16, 1'b0);
    chk1("rst_u16_perr", p16, 1'b0);
    chk1("rst_u16_done", i16, 1'b0);
    chk("rst_u12_data", d12, 32'h0);
    chk1("rst_u12_done", i12, 1'b0);

    init_seq();
    burst(16, 1'b1);

    for (int i = 0; i < 14; i++) apply(tbl[i]);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_add = 4'(i); wr_data = pat(i, 1'b0); wr_be = '1;
    end
    @(negedge clk);
    idle();
    burst(8, 1'b0);

    // Reset while a read is in flight: nothing may emerge and the sweep restarts.
    @(negedge clk);
    rd_en = 1'b1; rd_add = 4'd2;
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    chk1("mid_u16_vld", v16, 1'b0);
    chk1("mid_u12_vld", v12, 1'b0);
    chk1("mid_u16_done", i16, 1'b0);
    chk("mid_u12_data", d12, 32'h0);
    @(negedge clk);
    chk1("mid_u16_vld_s1", v16, 1'b0);
    @(negedge clk);
    chk1("mid_u16_vld_s2", v16, 1'b0);
    init_seq();
    apply('{1'b0, 4'd0, 32'h0, 4'b0000, 1'b0, 1'b1, 4'd3, 32'h0, 32'h0, 1'b0});

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
